// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer.
//   state_t   : top-level FSM states
//   LFSR_SEED : power-on LFSR value (must be nonzero)
//   LFSR_TAPS : Galois feedback mask, x^16 + x^14 + x^13 + x^11 + 1
//   width_for : number of bits needed to hold 0..max_val (minimum 1)
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ARMED,
    DONE,
    FOUL
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reaction_timer_multi_if.sv
// Player/display-side signal bundle of the reaction timer.
//   start, btn  : requests from the button pins (driven by master)
//   go, done, foul, winner, timeout, foul_mask, time_ms : results (driven by slave)
//   best_ms     : present only when BEST_TIME_EN is defined
// Modports: master = pin/display side, slave = reaction_timer_multi.
interface reaction_timer_multi_if #(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned CNT_W     = 12
);
  localparam int unsigned WIN_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

  logic                 start;
  logic [N_PLAYERS-1:0] btn;
  logic                 go;
  logic                 done;
  logic                 foul;
  logic [WIN_W-1:0]     winner;
  logic                 timeout;
  logic [N_PLAYERS-1:0] foul_mask;
  logic [CNT_W-1:0]     time_ms;
`ifdef BEST_TIME_EN
  logic [CNT_W-1:0]     best_ms;

  modport master (output start, btn,
                  input  go, done, foul, winner, timeout, foul_mask, time_ms, best_ms);
  modport slave  (input  start, btn,
                  output go, done, foul, winner, timeout, foul_mask, time_ms, best_ms);
`else
  modport master (output start, btn,
                  input  go, done, foul, winner, timeout, foul_mask, time_ms);
  modport slave  (input  start, btn,
                  output go, done, foul, winner, timeout, foul_mask, time_ms);
`endif

endinterface

// File: rtl/rt_btn_sync.sv
// One button channel: 2-FF synchroniser followed by rising-edge detect.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : holds the whole chain when low
//   btn        : raw asynchronous button, active-high
//   press      : one-cycle pulse per synchronised rising edge
module rt_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn,
  output logic press
);

  // [0],[1] synchronise; [2] is the previous synchronised value
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sh <= '0;
    else if (ena) sh <= {sh[1:0], btn};
  end

  assign press = sh[1] & ~sh[2];

endmodule

// File: rtl/reaction_timer_multi.sv
// N-player reaction-time tester. After start, waits MIN_DLY_MS plus an LFSR-derived
// random number of ms, raises go, then times in ms until the first player press.
// Presses before go are fouls; no press before the counter saturates is a timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : tile enable, low freezes everything
//   bus        : reaction_timer_multi_if.slave (start/btn in, results out)
// Optional: define BEST_TIME_EN to add bus.best_ms, the minimum non-timeout
// reaction time since reset.
module reaction_timer_multi
  import reaction_pkg::*;
#(
  parameter int unsigned N_PLAYERS  = 2,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned TICK_DIV   = 10000,
  parameter int unsigned LFSR_W     = 16,
  parameter int unsigned MIN_DLY_MS = 500,
  parameter int unsigned DLY_MASK   = 'h7FF
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   ena,
  reaction_timer_multi_if.slave bus
);

  localparam int unsigned PRE_W = width_for(TICK_DIV - 1);
  localparam int unsigned DLY_W = width_for(MIN_DLY_MS + DLY_MASK);
  localparam int unsigned WIN_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d, lfsr_masked;
  logic [DLY_W-1:0]     dly_q, dly_d, wcnt_q, wcnt_d, wcnt_inc;
  logic                 start_q, start_rise, tick;
  logic [N_PLAYERS-1:0] press;
  logic [WIN_W-1:0]     win_low;

  logic                 go_q, go_d, done_q, done_d, foul_q, foul_d, to_q, to_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [N_PLAYERS-1:0] fmask_q, fmask_d;
  logic [CNT_W-1:0]     time_q, time_d;
`ifdef BEST_TIME_EN
  logic [CNT_W-1:0]     best_q, best_d;
`endif

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_sync
    rt_btn_sync u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .btn  (bus.btn[g]),
      .press(press[g])
    );
  end

  assign start_rise  = bus.start & ~start_q;
  assign tick        = (pre_q == PRE_W'(TICK_DIV - 1));
  assign lfsr_masked = lfsr_q & LFSR_W'(DLY_MASK);
  assign wcnt_inc    = wcnt_q + 1'b1;
  assign lfsr_d      = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS[LFSR_W-1:0] : '0);

  always_comb begin
    win_low = '0;
    for (int unsigned i = N_PLAYERS; i > 0; i--) begin
      if (press[i-1]) win_low = WIN_W'(i - 1);
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = tick ? '0 : pre_q + 1'b1;
    dly_d   = dly_q;
    wcnt_d  = wcnt_q;
    go_d    = go_q;
    done_d  = done_q;
    foul_d  = foul_q;
    to_d    = to_q;
    win_d   = win_q;
    fmask_d = fmask_q;
    time_d  = time_q;
`ifdef BEST_TIME_EN
    best_d  = best_q;
`endif
    unique case (state_q)
      IDLE, DONE, FOUL: begin
        if (start_rise) begin
          state_d = WAIT;
          dly_d   = DLY_W'(MIN_DLY_MS) + DLY_W'(lfsr_masked);
          wcnt_d  = '0;
          pre_d   = '0;
          go_d    = 1'b0;
          done_d  = 1'b0;
          foul_d  = 1'b0;
          to_d    = 1'b0;
          win_d   = '0;
          fmask_d = '0;
          time_d  = '0;
        end
      end
      WAIT: begin
        // A press is checked before the tick so a press on the arming cycle is a foul
        if (|press) begin
          state_d = FOUL;
          foul_d  = 1'b1;
          fmask_d = fmask_q | press;
        end else if (tick) begin
          if (wcnt_inc == dly_q) begin
            state_d = ARMED;
            go_d    = 1'b1;
            time_d  = '0;
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
      end
      ARMED: begin
        // A press beats a coincident tick: time_ms keeps its current value
        if (|press) begin
          state_d = DONE;
          go_d    = 1'b0;
          done_d  = 1'b1;
          win_d   = win_low;
`ifdef BEST_TIME_EN
          if (time_q < best_q) best_d = time_q;
`endif
        end else if (tick) begin
          time_d = time_q + 1'b1;
          if (time_d == CNT_MAX) begin
            state_d = DONE;
            go_d    = 1'b0;
            done_d  = 1'b1;
            to_d    = 1'b1;
            win_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      lfsr_q  <= LFSR_SEED[LFSR_W-1:0];
      dly_q   <= '0;
      wcnt_q  <= '0;
      start_q <= 1'b0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      foul_q  <= 1'b0;
      to_q    <= 1'b0;
      win_q   <= '0;
      fmask_q <= '0;
      time_q  <= '0;
`ifdef BEST_TIME_EN
      best_q  <= '1;
`endif
    end else if (ena) begin
      state_q <= state_d;
      pre_q   <= pre_d;
      lfsr_q  <= lfsr_d;
      dly_q   <= dly_d;
      wcnt_q  <= wcnt_d;
      start_q <= bus.start;
      go_q    <= go_d;
      done_q  <= done_d;
      foul_q  <= foul_d;
      to_q    <= to_d;
      win_q   <= win_d;
      fmask_q <= fmask_d;
      time_q  <= time_d;
`ifdef BEST_TIME_EN
      best_q  <= best_d;
`endif
    end
  end

  assign bus.go        = go_q;
  assign bus.done      = done_q;
  assign bus.foul      = foul_q;
  assign bus.timeout   = to_q;
  assign bus.winner    = win_q;
  assign bus.foul_mask = fmask_q;
  assign bus.time_ms   = time_q;
`ifdef BEST_TIME_EN
  assign bus.best_ms   = best_q;
`endif

endmodule

// File: tb/tb_reaction_timer_multi.sv
module tb_reaction_timer_multi;
  localparam int unsigned NP = 2;
  localparam int unsigned CW = 6;
  localparam int unsigned TD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;
  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          done;
    logic          foul;
    logic          timeout;
    logic [0:0]    winner;
    logic [NP-1:0] fmask;
    logic [CW-1:0] time_ms;
  } res_t;

  res_t sb[$];

  reaction_timer_multi_if #(.N_PLAYERS(NP), .CNT_W(CW)) bus ();

  reaction_timer_multi #(
    .N_PLAYERS (NP),
    .CNT_W     (CW),
    .TICK_DIV  (TD),
    .LFSR_W    (16),
    .MIN_DLY_MS(3),
    .DLY_MASK  ('h3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  function automatic res_t observe();
    observe = {bus.done, bus.foul, bus.timeout, bus.winner, bus.foul_mask, bus.time_ms};
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("done=%0b foul=%0b timeout=%0b winner=%0d mask=%b time_ms=%0d",
                     r.done, r.foul, r.timeout, r.winner, r.fmask, r.time_ms);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    cycles(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_go(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycles(1);
      if (bus.go === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cycles(1);
      if (bus.done === 1'b1 || bus.foul === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // Called on the first cycle go is seen: lands the press between ticks ms and ms+1
  task automatic press_at(input int ms, input logic [NP-1:0] pat);
    cycles(ms * TD - 1);
    bus.btn = pat;
  endtask

  task automatic release_btn;
    bus.btn = '0;
    cycles(4);
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({bus.go, bus.done, bus.foul, bus.timeout} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got go/done/foul/timeout=%b expected 0000",
               {bus.go, bus.done, bus.foul, bus.timeout});
    end
    checks++;
    if (bus.foul_mask !== 2'b00) begin
      failures++; $display("FAIL reset_mask: got %b expected 00", bus.foul_mask);
    end
    checks++;
    if (bus.time_ms !== 6'd0) begin
      failures++; $display("FAIL reset_time: got %0d expected 0", bus.time_ms);
    end
    checks++;
    if (bus.winner !== 1'b0) begin
      failures++; $display("FAIL reset_winner: got %0d expected 0", bus.winner);
    end
`ifdef BEST_TIME_EN
    checks++;
    if (bus.best_ms !== 6'h3F) begin
      failures++; $display("FAIL reset_best: got %0d expected 63", bus.best_ms);
    end
`endif
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_start;
    wait_go(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid_go: got go=0 expected 1 within budget"); end
    cycles(20);
    checks++;
    if (bus.time_ms !== 6'd5) begin
      failures++; $display("FAIL rstmid_ticks: got time_ms=%0d expected 5", bus.time_ms);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.go !== 1'b0) begin failures++; $display("FAIL rstmid_go_low: got %b expected 0", bus.go); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.time_ms !== 6'd0) begin
      failures++; $display("FAIL rstmid_time: got %0d expected 0", bus.time_ms);
    end
    cycles(1);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_react;
    res_t exp, got;
    bit ok;
    sb.push_back('{done: 1'b1, foul: 1'b0, timeout: 1'b0, winner: 1'b1, fmask: '0, time_ms: 6'd10});
    do_start;
    wait_go(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL react_go: got go=0 expected 1 within budget"); end
    press_at(10, 2'b10);
    wait_end(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL react_end: got no done/foul expected done within budget"); end
    got = observe();
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL react: got %s expected %s", fmt(got), fmt(exp)); end
    checks++;
    if (bus.go !== 1'b0) begin failures++; $display("FAIL react_go_off: got %b expected 0", bus.go); end
    release_btn;
  endtask

  task automatic test_foul;
    res_t exp, got;
    bit ok, saw_go;
    sb.push_back('{done: 1'b0, foul: 1'b1, timeout: 1'b0, winner: 1'b0, fmask: 2'b01, time_ms: 6'd0});
    do_start;
    bus.btn = 2'b01;
    ok = 1'b0;
    saw_go = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (bus.go === 1'b1) saw_go = 1'b1;
      if (bus.foul === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL foul_end: got foul=0 expected 1 within budget"); end
    got = observe();
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL foul: got %s expected %s", fmt(got), fmt(exp)); end
    // a press in FOUL must not extend the mask; go must stay low
    bus.btn = 2'b11;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if (bus.go === 1'b1) saw_go = 1'b1;
    end
    checks++;
    if (saw_go) begin failures++; $display("FAIL foul_go: got go=1 at some point expected never"); end
    got = observe();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL foul_hold: got %s expected %s", fmt(got), fmt(exp)); end
    release_btn;
  endtask

  task automatic test_tie;
    res_t exp, got;
    bit ok;
    sb.push_back('{done: 1'b1, foul: 1'b0, timeout: 1'b0, winner: 1'b0, fmask: '0, time_ms: 6'd5});
    do_start;
    wait_go(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL tie_go: got go=0 expected 1 within budget"); end
    press_at(5, 2'b11);
    wait_end(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL tie_end: got no done expected done within budget"); end
    got = observe();
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL tie: got %s expected %s", fmt(got), fmt(exp)); end
    release_btn;
    bus.btn = 2'b10;
    cycles(10);
    got = observe();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL tie_after: got %s expected %s", fmt(got), fmt(exp)); end
    release_btn;
  endtask

  task automatic test_timeout;
    res_t exp, got;
    bit ok;
    sb.push_back('{done: 1'b1, foul: 1'b0, timeout: 1'b1, winner: 1'b0, fmask: '0, time_ms: 6'd63});
    do_start;
    wait_go(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_go: got go=0 expected 1 within budget"); end
    wait_end(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_end: got no done expected done within budget"); end
    got = observe();
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL timeout: got %s expected %s", fmt(got), fmt(exp)); end
    checks++;
    if (bus.go !== 1'b0) begin failures++; $display("FAIL timeout_go_off: got %b expected 0", bus.go); end
  endtask

  task automatic test_ena;
    res_t exp, got;
    bit ok;
    sb.push_back('{done: 1'b1, foul: 1'b0, timeout: 1'b0, winner: 1'b1, fmask: '0, time_ms: 6'd6});
    do_start;
    wait_go(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ena_go: got go=0 expected 1 within budget"); end
    cycles(10);
    ena = 1'b0;
    cycles(30);
    checks++;
    if (bus.time_ms !== 6'd2) begin
      failures++; $display("FAIL ena_frozen_time: got %0d expected 2", bus.time_ms);
    end
    checks++;
    if (bus.go !== 1'b1) begin failures++; $display("FAIL ena_frozen_go: got %b expected 1", bus.go); end
    ena = 1'b1;
    cycles(13);
    bus.btn = 2'b10;
    wait_end(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ena_end: got no done expected done within budget"); end
    got = observe();
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL ena: got %s expected %s", fmt(got), fmt(exp)); end
    release_btn;
  endtask

`ifdef BEST_TIME_EN
  task automatic test_best;
    int runs[3] = '{10, 7, 12};
    logic [CW-1:0] best_exp;
    res_t exp, got;
    bit ok;
    do_reset;
    best_exp = '1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{done: 1'b1, foul: 1'b0, timeout: 1'b0, winner: 1'b0, fmask: '0,
                     time_ms: CW'(runs[i])});
      do_start;
      wait_go(ok);
      press_at(runs[i], 2'b01);
      wait_end(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL best_end%0d: got no done expected done", i); end
      got = observe();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL best_run%0d: got %s expected %s", i, fmt(got), fmt(exp)); end
      if (CW'(runs[i]) < best_exp) best_exp = CW'(runs[i]);
      checks++;
      if (bus.best_ms !== best_exp) begin
        failures++; $display("FAIL best_val%0d: got %0d expected %0d", i, bus.best_ms, best_exp);
      end
      release_btn;
    end
    do_start;
    wait_go(ok);
    wait_end(ok);
    checks++;
    if (bus.timeout !== 1'b1) begin failures++; $display("FAIL best_to: got timeout=%b expected 1", bus.timeout); end
    checks++;
    if (bus.best_ms !== 6'd7) begin
      failures++; $display("FAIL best_after_timeout: got %0d expected 7", bus.best_ms);
    end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.btn   = '0;
    test_reset;
    test_reset_mid;
    test_react;
    test_foul;
    test_tie;
    test_timeout;
    test_ena;
`ifdef BEST_TIME_EN
    test_best;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
